// File: rtl/vga_console_scroll.sv
// Text console with a circular row buffer, hardware scroll and a two-stage
// pixel render pipeline. Characters arrive over a valid/ready handshake;
// line feeds past the bottom row advance top_row and blank the new bottom
// row one cell per cycle.
module vga_console_scroll #(
  parameter int COLS      = 32,
  parameter int ROWS      = 16,
  parameter int FONT_MULT = 4,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      char_valid,
  input  logic [7:0]                char_data,
  output logic                      char_ready,
  input  logic                      clear,
  input  logic                      cursor_en,
  input  logic [11:0]               pixel_x,
  input  logic [11:0]               pixel_y,
  output logic                      font_set,
  output logic                      busy,
  output logic [$clog2(COLS)-1:0]   cursor_col,
  output logic [$clog2(ROWS)-1:0]   cursor_row
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int AW    = CW + RW;
  localparam int DEPTH = 1 << AW;
  localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CLR_ROW = 2'd1;
  localparam logic [1:0] S_CLR_ALL = 2'd2;

  logic [1:0]    state;
  logic [RW-1:0] top_row;
  logic [CW-1:0] clr_col;
  logic [RW-1:0] clr_row;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  logic [7:0]    mem [DEPTH];

  // Logical row -> physical row in the circular buffer (ROWS need not be 2^n).
  function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] lrow,
                                             input logic [RW-1:0] top);
    logic [RW:0] sum;
    sum = {1'b0, lrow} + {1'b0, top};
    if (sum >= (RW+1)'(ROWS)) sum = sum - (RW+1)'(ROWS);
    return sum[RW-1:0];
  endfunction

  // Glyph rows, bit 7 is the leftmost pixel. Blank for 0x00 and space.
  function automatic logic [7:0] font_mem(input logic [7:0] code,
                                          input logic [3:0] gy);
    logic [7:0] row;
    row = 8'h00;
    if (code == 8'h41) begin
      case (gy)
        4'd2:                             row = 8'h10;
        4'd3:                             row = 8'h38;
        4'd4:                             row = 8'h6C;
        4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11: row = 8'hC6;
        4'd7:                             row = 8'hFE;
        default:                          row = 8'h00;
      endcase
    end else if (code > 8'h20 && code <= 8'h7E) begin
      if (gy == 4'd2 || gy == 4'd13)       row = 8'h7E;
      else if (gy >= 4'd3 && gy <= 4'd12)  row = 8'h42;
    end
    return row;
  endfunction

  // Handshake and character decode.
  logic accept, is_print, is_lf, is_cr, is_bs, do_lf;
  logic [RW-1:0] cur_phys;

  assign char_ready = (state == S_IDLE) && !clear;
  assign busy       = (state != S_IDLE);
  assign accept     = char_valid && char_ready;
  assign is_print   = (char_data >= 8'h20) && (char_data <= 8'h7E);
  assign is_lf      = (char_data == 8'h0A);
  assign is_cr      = (char_data == 8'h0D);
  assign is_bs      = (char_data == 8'h08) && (cursor_col != '0);
  assign do_lf      = is_lf || (is_print && cursor_col == COL_LAST);
  assign cur_phys   = phys_row(cursor_row, top_row);

  // Single buffer write port: character/backspace writes in IDLE, sweeps otherwise.
  logic          we;
  logic [RW-1:0] wa_row;
  logic [CW-1:0] wa_col;
  logic [7:0]    wd;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    we     = 1'b0;
    wa_row = cur_phys;
    wa_col = cursor_col;
    wd     = 8'h00;
    case (state)
      S_IDLE: begin
        if (accept && is_print) begin
          we = 1'b1;
          wd = char_data;
        end else if (accept && is_bs) begin
          we     = 1'b1;
          wa_col = cursor_col - CW'(1);
        end
      end
      default: begin
        we     = 1'b1;
        wa_row = clr_row;
        wa_col = clr_col;
      end
    endcase
  end

  // Render stage 1 address and flags.
  logic [11:0]   scaled_x, scaled_y, cell_x, cell_y;
  logic          in_range, cursor_hit;
  logic [AW-1:0] raddr;

  assign scaled_x   = pixel_x / 12'(FONT_MULT);
  assign scaled_y   = pixel_y / 12'(FONT_MULT);
  assign cell_x     = scaled_x >> 3;
  assign cell_y     = scaled_y >> 4;
  assign in_range   = (cell_x < 12'(COLS)) && (cell_y < 12'(ROWS));
  assign raddr      = {phys_row(cell_y[RW-1:0], top_row), cell_x[CW-1:0]};
  assign cursor_hit = in_range && cursor_en && blink_phase &&
                      (cell_x[CW-1:0] == cursor_col) && (cell_y[RW-1:0] == cursor_row);

  logic [7:0] rd_data;

  // Character buffer: one write port, one registered read port for rendering.
  // NOTE: the buffer has no reset; the CLR_ALL sweep after reset blanks it instead.
  always_ff @(posedge clk) begin
    if (we) mem[{wa_row, wa_col}] <= wd;
    rd_data <= mem[raddr];
  end

  // Control state: cursor, top_row, clear sweeps.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_CLR_ALL;
      cursor_col <= '0;
      cursor_row <= '0;
      top_row    <= '0;
      clr_col    <= '0;
      clr_row    <= '0;
    end else if (clear) begin
      state      <= S_CLR_ALL;
      cursor_col <= '0;
      cursor_row <= '0;
      top_row    <= '0;
      clr_col    <= '0;
      clr_row    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_print)   cursor_col <= (cursor_col == COL_LAST) ? '0 : cursor_col + CW'(1);
            if (is_lf || is_cr) cursor_col <= '0;
            if (is_bs)      cursor_col <= cursor_col - CW'(1);
            if (do_lf) begin
              if (cursor_row == ROW_LAST) begin
                // New bottom logical row maps onto the old top physical row.
                top_row <= (top_row == ROW_LAST) ? '0 : top_row + RW'(1);
                clr_row <= top_row;
                clr_col <= '0;
                state   <= S_CLR_ROW;
              end else begin
                cursor_row <= cursor_row + RW'(1);
              end
            end
          end
        end
        S_CLR_ROW: begin
          clr_col <= clr_col + CW'(1);
          if (clr_col == COL_LAST) state <= S_IDLE;
        end
        S_CLR_ALL: begin
          clr_col <= clr_col + CW'(1);
          if (clr_col == COL_LAST) begin
            clr_row <= (clr_row == ROW_LAST) ? '0 : clr_row + RW'(1);
            if (clr_row == ROW_LAST) state <= S_IDLE;
          end
        end
        default: state <= S_CLR_ALL;
      endcase
    end
  end

  // Free-running cursor blink divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Render pipeline: stage 1 registers glyph coordinates and flags, stage 2 the pixel.
  logic [2:0] s1_gx;
  logic [3:0] s1_gy;
  logic       s1_in, s1_hit;
  logic [7:0] glyph_row;

  assign glyph_row = font_mem(rd_data, s1_gy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_gx    <= '0;
      s1_gy    <= '0;
      s1_in    <= 1'b0;
      s1_hit   <= 1'b0;
      font_set <= 1'b0;
    end else begin
      s1_gx    <= scaled_x[2:0];
      s1_gy    <= scaled_y[3:0];
      s1_in    <= in_range;
      s1_hit   <= cursor_hit;
      font_set <= s1_in && (glyph_row[~s1_gx] ^ s1_hit);
    end
  end

endmodule

// File: tb/tb_vga_console_scroll.sv
// Self-checking bench for vga_console_scroll: directed scenarios followed by
// random character traffic, checked against a logical-screen reference model.
module tb_vga_console_scroll;

  localparam int COLS = 32;
  localparam int ROWS = 16;
  localparam int FM   = 4;
  localparam int BD   = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        clear = 1'b0;
  logic        cursor_en = 1'b0;
  logic [11:0] pixel_x = '0;
  logic [11:0] pixel_y = '0;
  logic        char_ready, font_set, busy;
  logic [4:0]  cursor_col;
  logic [3:0]  cursor_row;

  vga_console_scroll #(.COLS(COLS), .ROWS(ROWS), .FONT_MULT(FM), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .clear(clear), .cursor_en(cursor_en),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .font_set(font_set), .busy(busy),
    .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release, for the blink phase model.
  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: screen as seen by the viewer, in logical rows.
  logic [7:0] scr [ROWS][COLS];
  int mrow, mcol;

  string glyph_a [16] = '{
    "........", "........", "...#....", "..###...",
    ".##.##..", "##...##.", "##...##.", "#######.",
    "##...##.", "##...##.", "##...##.", "##...##.",
    "........", "........", "........", "........"};

  function automatic bit glyph_px(logic [7:0] c, int gx, int gy);
    string s;
    if (c == 8'h41) begin
      s = glyph_a[gy];
      return s[gx] == 8'h23;
    end
    if (c > 8'h20 && c <= 8'h7E)
      return ((gy == 2 || gy == 13) && gx >= 1 && gx <= 6) ||
             (gy >= 3 && gy <= 12 && (gx == 1 || gx == 6));
    return 1'b0;
  endfunction

  function automatic bit model_px(int px, int py);
    int cx, cy, gx, gy;
    bit hit;
    cx = px / FM / 8;
    cy = py / FM / 16;
    if (cx >= COLS || cy >= ROWS) return 1'b0;
    gx = (px / FM) % 8;
    gy = (py / FM) % 16;
    hit = cursor_en && ((cyc / BD) % 2 == 1) && cx == mcol && cy == mrow;
    return glyph_px(scr[cy][cx], gx, gy) ^ hit;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = 8'h00;
    mrow = 0;
    mcol = 0;
  endfunction

  function automatic void model_lf();
    if (mrow == ROWS - 1) begin
      for (int r = 0; r < ROWS - 1; r++) scr[r] = scr[r+1];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h00;
    end else begin
      mrow++;
    end
  endfunction

  function automatic void model_apply(logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      scr[mrow][mcol] = c;
      if (mcol == COLS - 1) begin mcol = 0; model_lf(); end
      else mcol++;
    end else if (c == 8'h0A) begin
      mcol = 0;
      model_lf();
    end else if (c == 8'h0D) begin
      mcol = 0;
    end else if (c == 8'h08 && mcol > 0) begin
      mcol--;
      scr[mrow][mcol] = 8'h00;
    end
  endfunction

  function automatic logic [7:0] rand_char();
    int r;
    logic [7:0] junk [5];
    junk = '{8'h00, 8'h7F, 8'h1B, 8'hFF, 8'h09};
    r = $urandom_range(0, 15);
    if (r <= 8)  return 8'($urandom_range(32, 126));
    if (r <= 10) return 8'h0A;
    if (r == 11) return 8'h0D;
    if (r <= 13) return 8'h08;
    if (r == 14) return junk[$urandom_range(0, 4)];
    return 8'h41;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    check("idle_timeout", busy, 0);
  endtask

  task automatic count_busy(input string tag, input int exp);
    int n = 0;
    while (busy && n < 5000) begin n++; @(negedge clk); end
    check(tag, n, exp);
  endtask

  task automatic send(input logic [7:0] c);
    int n = 0;
    while (!char_ready && n < 5000) begin @(negedge clk); n++; end
    check("ready_timeout", char_ready, 1);
    char_valid = 1'b1;
    char_data  = c;
    @(negedge clk);
    char_valid = 1'b0;
    model_apply(c);
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_col"}, cursor_col, mcol);
    check({tag, "_row"}, cursor_row, mrow);
  endtask

  task automatic check_pixel(input string tag, input int px, input int py);
    wait_idle();
    pixel_x = 12'(px);
    pixel_y = 12'(py);
    repeat (3) @(negedge clk);
    if ((cyc % BD) < 4) repeat (5) @(negedge clk);
    check(tag, font_set, model_px(px, py));
  endtask

  task automatic check_cell(input string tag, input int cx, input int cy);
    int gys [3];
    gys = '{2, 7, 12};
    for (int k = 0; k < 3; k++)
      for (int gx = 0; gx < 8; gx++)
        check_pixel(tag, cx*FM*8 + gx*FM + $urandom_range(0, FM-1),
                    cy*FM*16 + gys[k]*FM + $urandom_range(0, FM-1));
  endtask

  initial begin
    bit exp_q [$];
    model_clear();

    // Reset values while rst_n is low.
    repeat (3) @(negedge clk);
    check("rst_ready", char_ready, 0);
    check("rst_font", font_set, 0);
    check("rst_col", cursor_col, 0);
    check("rst_row", cursor_row, 0);

    // Boot sweep: busy for COLS*ROWS cycles.
    rst_n = 1'b1;
    count_busy("boot_busy", COLS*ROWS);
    check("boot_ready", char_ready, 1);
    check_cursor("boot");

    // Single 'A' and a full pixel sweep of its cell with 2-cycle latency.
    send(8'h41);
    check_cursor("after_A");
    for (int i = 0; i < 32*64 + 2; i++) begin
      if (i >= 2) check("render_A", font_set, exp_q.pop_front());
      if (i < 32*64) begin
        pixel_x = 12'(i % 32);
        pixel_y = 12'(i / 32);
        exp_q.push_back(model_px(i % 32, i / 32));
      end
      @(negedge clk);
    end

    // 33 printable characters in total: wrap to row 1.
    for (int i = 1; i <= 32; i++)
      send(i == 32 ? 8'h41 : 8'($urandom_range(33, 126)));
    check_cursor("wrap");
    check_cell("wrap_cell01", 0, 1);
    check_cell("wrap_cell10", 1, 0);

    // Backspace at column 0 and column 5.
    send(8'h0D);
    check_cursor("cr");
    send(8'h08);
    check_cursor("bs_col0");
    repeat (5) send(8'h41);
    check_cursor("five_A");
    send(8'h08);
    check_cursor("bs_col5");
    check_cell("bs_cell4", 4, 1);
    check_cell("bs_cell3", 3, 1);

    // Fill down to the last row, then scroll.
    while (mrow < ROWS - 1) begin
      send($urandom_range(0, 1) ? 8'h41 : 8'($urandom_range(33, 126)));
      send(8'h0A);
    end
    send(8'h41);
    send(8'h0A);
    count_busy("scroll_busy", COLS);
    check_cursor("scroll");
    check_cell("scroll_bottom0", 0, ROWS-1);
    check_cell("scroll_top0", 0, 0);
    check_cell("scroll_top4", 4, 0);

    // Clear during the row clear.
    send(8'h0A);
    check("clrrow_busy", busy, 1);
    clear = 1'b1;
    #1;
    check("clear_ready", char_ready, 0);
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    count_busy("clear_busy", COLS*ROWS);
    check_cursor("clear");
    check_cell("clear_cell00", 0, 0);
    check_cell("clear_cell_last", COLS-1, ROWS-1);

    // Out-of-range pixels alias onto cell (0,0) holding 'A' and must stay dark.
    send(8'h41);
    check_pixel("oor_x", COLS*FM*8 + 3*FM, 7*FM);
    check_pixel("oor_y", 3*FM, ROWS*FM*16 + 7*FM);
    check_pixel("in_range_A", 3*FM, 7*FM);

    // Cursor inversion in both blink phases.
    cursor_en = 1'b1;
    for (int ph = 1; ph >= 0; ph--) begin
      int n = 0;
      while (!(((cyc / BD) % 2 == ph) && (cyc % BD) >= 10 && (cyc % BD) <= BD - 40) && n < 1000) begin
        @(negedge clk);
        n++;
      end
      check_pixel("cursor_blank", mcol*FM*8 + 2*FM, mrow*FM*16 + 5*FM);
      check_pixel("cursor_other", 3*FM, 7*FM);
    end

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 63) == 0) begin
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
      end else begin
        send(rand_char());
      end
      check_cursor("rand");
      if (k % 8 == 7) begin
        cursor_en = 1'($urandom_range(0, 1));
        check_pixel("rand_cursor", mcol*FM*8 + $urandom_range(0, 31), mrow*FM*16 + $urandom_range(0, 63));
        for (int j = 0; j < 3; j++)
          check_pixel("rand_px", $urandom_range(0, 1279), $urandom_range(0, 1279));
      end
    end

    // Reset in the middle of a clear sweep.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", char_ready, 0);
    check("midrst_font", font_set, 0);
    model_clear();
    check_cursor("midrst");
    rst_n = 1'b1;
    count_busy("midrst_busy", COLS*ROWS);
    send(8'h41);
    check_cursor("midrst_A");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_console_scroll.md
VGA_CONSOLE_SCROLL -- requirements
Module: vga_console_scroll

Interface
REQ-001 SHALL have parameter COLS, default 32, meaning text columns; power of two, 4..128.
REQ-002 SHALL have parameter ROWS, default 16, meaning text rows, 2..64.
REQ-003 SHALL have parameter FONT_MULT, default 4, meaning pixel scale per glyph pixel; glyph cell is 8x16 before scaling.
REQ-004 SHALL have parameter BLINK_DIV, default 25000000, meaning clocks per cursor blink phase.
REQ-005 SHALL have port clk  input  1  meaning the single clock for all logic.
REQ-006 SHALL have port rst_n  input  1  meaning reset, asynchronous, active-low.
REQ-007 SHALL have port char_valid  input  1  meaning char_data is offered.
REQ-008 SHALL have port char_data  input  8  meaning character or control code.
REQ-009 SHALL have port char_ready  output  1  meaning the block accepts char_data this cycle.
REQ-010 SHALL have port clear  input  1  meaning synchronous request to clear the screen.
REQ-011 SHALL have port cursor_en  input  1  meaning show the blinking cursor.
REQ-012 SHALL have port pixel_x  input  12  meaning current pixel column.
REQ-013 SHALL have port pixel_y  input  12  meaning current pixel row.
REQ-014 SHALL have port font_set  output  1  meaning pixel lit, registered.
REQ-015 SHALL have port busy  output  1  meaning a clear or scroll operation is in progress.
REQ-016 SHALL have port cursor_col  output  clog2(COLS)  meaning current cursor column.
REQ-017 SHALL have port cursor_row  output  clog2(ROWS)  meaning current logical cursor row.

Function
REQ-018 SHALL hold COLS*ROWS bytes as a circular row buffer; physical row = (logical row + top_row) mod ROWS.
REQ-019 SHALL implement states IDLE, CLR_ROW, CLR_ALL; char_ready = (state==IDLE) && !clear; busy = (state!=IDLE).
REQ-020 SHALL process a character on a cycle where char_valid && char_ready; all updates are visible on the next cycle.
REQ-021 SHALL handle printable 0x20..0x7E this way: write the character at the cursor cell and increment cursor_col; from column COLS-1, set cursor_col to 0 and perform a line feed.
REQ-022 SHALL handle 0x0A as a line feed: set cursor_col to 0 and increment cursor_row; at row ROWS-1, scroll instead.
REQ-023 SHALL handle 0x0D by setting cursor_col to 0 with no other change.
REQ-024 SHALL handle 0x08 (backspace) at cursor_col>0 by decrementing cursor_col and writing 0x00 at the new cell; at cursor_col 0 it is a no-op.
REQ-025 SHALL discard all other codes, including 0x00, with no state change.
REQ-026 SHALL scroll this way: top_row <= (top_row+1) mod ROWS; cursor_row stays ROWS-1; enter CLR_ROW, writing 0x00 to the COLS cells of the new bottom physical row, one per cycle.
REQ-027 SHALL return to IDLE from CLR_ROW after exactly COLS cycles.
REQ-028 SHALL, when clear is high in any state, enter CLR_ALL next cycle, aborting any CLR_ROW, with cursor (0,0) and top_row 0.
REQ-029 SHALL write 0x00 to all COLS*ROWS cells in CLR_ALL, one per cycle, then return to IDLE; clear held high restarts the sweep.
REQ-030 SHALL drive the render pipeline, latency exactly 2 clk, as follows:
- stage 1 registers the cell address, glyph_x = (pixel_x/FONT_MULT)%8, glyph_y = (pixel_y/FONT_MULT)%16, the in-range flag and the cursor-hit flag, and performs a registered buffer read;
- stage 2 applies the existing font_mem lookup and registers font_set.
REQ-031 SHALL output font_set 0 when pixel_x/FONT_MULT/8 >= COLS or pixel_y/FONT_MULT/16 >= ROWS.
REQ-032 SHALL output the inverted glyph at the cursor cell when cursor_en is set and the blink phase is high.
REQ-033 SHALL toggle the blink phase every BLINK_DIV clocks, free-running in all states.
REQ-034 SHALL let the render read proceed during clears; cells not yet cleared may show old content.

Reset
REQ-035 SHALL, while rst_n is low, drive font_set=0, char_ready=0, cursor (0,0), top_row=0, blink phase 0 and blink counter 0.
REQ-036 SHALL leave reset in CLR_ALL, with busy=1 for exactly COLS*ROWS cycles after rst_n rises, then IDLE; buffer contents are not reset asynchronously.
REQ-037 SHALL, on rst_n assertion mid-operation, abort immediately and restart per REQ-036.

Verification
REQ-038 SHALL pass: release reset -> busy high 512 cycles (32x16), then char_ready=1, cursor (0,0).
REQ-039 SHALL pass: send 'A' (0x41) with pixel (0,0)..(31,63) -> cursor_col=1; font_set matches the 'A' glyph scaled x4, 2 cycles late.
REQ-040 SHALL pass: send 33 printable chars -> wrap to row 1, cursor (1,1); the char at index 32 is at cell (0,1).
REQ-041 SHALL pass: fill to row 15 then send 0x0A -> top_row=1, busy 32 cycles, cursor (0,15), bottom row blank, old row 1 displayed at row 0.
REQ-042 SHALL pass: 0x08 at col 0 -> no change; 0x08 at col 5 -> col 4, cell 4 reads 0x00.
REQ-043 SHALL pass: assert clear during CLR_ROW -> CLR_ALL next cycle, 512 busy cycles, cursor (0,0), all cells 0x00.
